ref_timer: RTL and testbench

- DRAM refresh request generator; sits directly upstream of the RAM controller and drives its RefReqIn/RefUrgIn inputs.
- Counts a fixed refresh interval and tracks owed refreshes ("debt").
- Escalates a pending request to urgent when it ages or debt accumulates.
- Consumes the controller's refresh-in-progress indication as acknowledge.

---
 rtl/ref_timer_pkg.sv | 16 +
 rtl/ref_prescaler.sv | 29 ++
 rtl/ref_timer.sv | 125 ++++++++++++
 tb/tb_ref_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ref_timer_pkg.sv
// rtl/ref_timer_pkg.sv - shared state encoding and default timing for the refresh timer
package ref_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_URG  = 2'd2,
    ST_GAP  = 2'd3
  } ref_state_t;

  localparam int DEF_REF_PERIOD = 390;
  localparam int DEF_URG_AGE    = 64;
  localparam int DEF_MAX_DEBT   = 4;
  localparam int DEF_DW         = 3;

endpackage

// File: rtl/ref_prescaler.sv
// rtl/ref_prescaler.sv - refresh period counter; tick is the wrap cycle
module ref_prescaler
  import ref_timer_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  input  logic En,
  output logic tick
);

  localparam int CW = $clog2(REF_PERIOD);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(REF_PERIOD - 1));
  assign tick = En && wrap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ref_timer.sv
// rtl/ref_timer.sv - DRAM refresh request generator with debt tracking and urgency escalation
module ref_timer
  import ref_timer_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int URG_AGE    = DEF_URG_AGE,
  parameter int MAX_DEBT   = DEF_MAX_DEBT,
  parameter int DW         = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          En,
  input  logic          RefAck,
  output logic          RefReq,
  output logic          RefUrg,
  output logic [DW-1:0] Debt,
  output logic          Overflow
);

  localparam int AW = $clog2(URG_AGE + 1);

  ref_state_t    state;
  logic          tick;
  logic          ack_q;
  logic          ack_rise;
  logic [DW-1:0] debt;
  logic [DW-1:0] debt_nxt;
  logic [AW-1:0] age;
  logic [AW-1:0] age_nxt;
  logic          ovf_set;
  logic          urg_cond;

  ref_prescaler #(.REF_PERIOD(REF_PERIOD)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .En   (En),
    .tick (tick)
  );

  // A multi-cycle refresh from the controller must only retire one debt.
  assign ack_rise = RefAck && !ack_q;
  assign Debt     = debt;

  always_comb begin
    debt_nxt = debt;
    ovf_set  = 1'b0;
    if (tick && !ack_rise) begin
      if (debt == DW'(MAX_DEBT)) ovf_set = 1'b1;
      else                       debt_nxt = debt + DW'(1);
    end else if (ack_rise && !tick && debt != '0) begin
      debt_nxt = debt - DW'(1);
    end
  end

  always_comb begin
    age_nxt = age;
    if (ack_rise || debt == '0)       age_nxt = '0;
    else if (age != AW'(URG_AGE))     age_nxt = age + AW'(1);
  end

  // Decisions use next-cycle debt/age so the registered outputs land one cycle after the cause.
  assign urg_cond = (age_nxt == AW'(URG_AGE)) || (debt_nxt >= DW'(2));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      ack_q    <= 1'b0;
      debt     <= '0;
      age      <= '0;
      RefReq   <= 1'b0;
      RefUrg   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      ack_q <= RefAck;
      debt  <= debt_nxt;
      age   <= age_nxt;
      if (ovf_set) Overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (debt_nxt != '0) begin
            state  <= ST_PEND;
            RefReq <= 1'b1;
          end
        end
        ST_PEND: begin
          if (ack_rise) begin
            state  <= ST_GAP;
            RefReq <= 1'b0;
          end else if (urg_cond) begin
            state  <= ST_URG;
            RefUrg <= 1'b1;
          end
        end
        ST_URG: begin
          if (ack_rise) begin
            state  <= ST_GAP;
            RefReq <= 1'b0;
            RefUrg <= 1'b0;
          end
        end
        ST_GAP: begin
          // Both request lines must be seen low before the controller accepts a new request.
          if (!RefAck) begin
            if (debt_nxt == '0) begin
              state <= ST_IDLE;
            end else if (urg_cond) begin
              state  <= ST_URG;
              RefReq <= 1'b1;
              RefUrg <= 1'b1;
            end else begin
              state  <= ST_PEND;
              RefReq <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          RefReq <= 1'b0;
          RefUrg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ref_timer.sv
// tb/tb_ref_timer.sv - directed table and randomized model checks for ref_timer
module tb_ref_timer;

  localparam int P  = 390;
  localparam int A  = 64;
  localparam int MD = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       En = 1'b0;
  logic       RefAck = 1'b0;
  logic       RefReq;
  logic       RefUrg;
  logic [2:0] Debt;
  logic       Overflow;

  always #5 CLK = ~CLK;

  ref_timer #(.REF_PERIOD(P), .URG_AGE(A), .MAX_DEBT(MD), .DW(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .En       (En),
    .RefAck   (RefAck),
    .RefReq   (RefReq),
    .RefUrg   (RefUrg),
    .Debt     (Debt),
    .Overflow (Overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_print  = 0;

  // Reference model: integer counters plus "request visible / in gap" flags.
  int m_cnt = 0, m_debt = 0, m_age = 0;
  bit m_ovf = 0, m_prev_ack = 0, m_req = 0, m_urg = 0, m_gap = 0;

  task automatic model_step(input bit rst, input bit en, input bit ack);
    bit tick, rise, ucond;
    int debt_n, age_n;
    if (rst) begin
      m_cnt = 0; m_debt = 0; m_age = 0;
      m_ovf = 0; m_prev_ack = 0; m_req = 0; m_urg = 0; m_gap = 0;
      return;
    end
    tick   = en && (m_cnt == P - 1);
    rise   = ack && !m_prev_ack;
    debt_n = m_debt;
    if (tick && !rise) begin
      if (m_debt == MD) m_ovf = 1;
      else debt_n = m_debt + 1;
    end else if (rise && !tick) begin
      debt_n = (m_debt > 0) ? m_debt - 1 : 0;
    end
    age_n = (rise || m_debt == 0) ? 0 : ((m_age + 1 > A) ? A : m_age + 1);
    ucond = (age_n == A) || (debt_n >= 2);
    if (m_gap) begin
      if (!ack) begin
        m_gap = 0;
        m_req = (debt_n > 0);
        m_urg = m_req && ucond;
      end
    end else if (m_req && rise) begin
      m_gap = 1; m_req = 0; m_urg = 0;
    end else if (!m_req) begin
      m_req = (debt_n > 0);
      m_urg = 0;
    end else if (!m_urg) begin
      m_urg = ucond;
    end
    m_debt     = debt_n;
    m_age      = age_n;
    m_cnt      = en ? (m_cnt + 1) % P : m_cnt;
    m_prev_ack = ack;
  endtask

  task automatic check_model();
    n_checks++;
    if (RefReq !== m_req || RefUrg !== m_urg || int'(Debt) != m_debt || Overflow !== m_ovf) begin
      n_fail++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL model_cycle t=%0t got req=%0b urg=%0b debt=%0d ovf=%0b want req=%0b urg=%0b debt=%0d ovf=%0b",
                 $time, RefReq, RefUrg, Debt, Overflow, m_req, m_urg, m_debt, m_ovf);
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit ack);
    RST = rst; En = en; RefAck = ack;
    @(posedge CLK);
    model_step(rst, en, ack);
    #1;
    check_model();
  endtask

  typedef struct {
    string name;
    int    n;
    bit    rst, en, ack;
    bit    req, urg;
    int    debt;
    bit    ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input int n, input bit rst, input bit en,
                              input bit ack, input bit req, input bit urg, input int debt,
                              input bit ovf);
    vec_t v;
    v.name = name; v.n = n; v.rst = rst; v.en = en; v.ack = ack;
    v.req = req; v.urg = urg; v.debt = debt; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    //  name                  cycles   rst en ack   req urg debt ovf
    add("reset",              1,       1, 0, 0,     0, 0, 0, 0);
    add("no_early_req",       P - 1,   0, 1, 0,     0, 0, 0, 0);
    add("first_req",          1,       0, 1, 0,     1, 0, 1, 0);
    add("ack_drop",           1,       0, 1, 1,     0, 0, 0, 0);
    add("ack_held_once",      1,       0, 1, 1,     0, 0, 0, 0);
    add("gap_to_idle",        1,       0, 1, 0,     0, 0, 0, 0);
    add("idle_before_tick2",  P - 4,   0, 1, 0,     0, 0, 0, 0);
    add("tick2_req",          1,       0, 1, 0,     1, 0, 1, 0);
    add("pre_urg",            A - 1,   0, 1, 0,     1, 0, 1, 0);
    add("urg_at_age",         1,       0, 1, 0,     1, 1, 1, 0);
    add("pre_tick3",          P - A - 1, 0, 1, 0,   1, 1, 1, 0);
    add("debt2",              1,       0, 1, 0,     1, 1, 2, 0);
    add("debt3",              P,       0, 1, 0,     1, 1, 3, 0);
    add("ack_a_gap",          1,       0, 1, 1,     0, 0, 2, 0);
    add("ack_a_reassert",     1,       0, 1, 0,     1, 1, 2, 0);
    add("ack_b_gap",          1,       0, 1, 1,     0, 0, 1, 0);
    add("ack_b_reassert",     1,       0, 1, 0,     1, 0, 1, 0);
    add("ack_c_gap",          1,       0, 1, 1,     0, 0, 0, 0);
    add("ack_c_idle",         1,       0, 1, 0,     0, 0, 0, 0);
    add("idle_before_tick4",  P - 7,   0, 1, 0,     0, 0, 0, 0);
    add("tick4",              1,       0, 1, 0,     1, 0, 1, 0);
    add("pre_coincide",       P - 1,   0, 1, 0,     1, 1, 1, 0);
    add("coincide_gap",       1,       0, 1, 1,     0, 0, 1, 0);
    add("coincide_pend",      1,       0, 1, 0,     1, 0, 1, 0);
    add("sat4",               3*P - 1, 0, 1, 0,     1, 1, 4, 0);
    add("overflow",           P,       0, 1, 0,     1, 1, 4, 1);
    add("ovf_sticky_gap",     1,       0, 1, 1,     0, 0, 3, 1);
    add("ovf_reassert",       1,       0, 1, 0,     1, 1, 3, 1);
    add("en_low_hold",        1000,    0, 0, 0,     1, 1, 3, 1);
    add("resume_no_tick",     P - 3,   0, 1, 0,     1, 1, 3, 1);
    add("resume_tick",        1,       0, 1, 0,     1, 1, 4, 1);
    add("rst_mid",            1,       1, 1, 0,     0, 0, 0, 0);
    add("post_rst_idle",      1,       0, 0, 0,     0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].rst, tbl[i].en, tbl[i].ack);
      n_checks++;
      if (RefReq !== tbl[i].req || RefUrg !== tbl[i].urg ||
          int'(Debt) != tbl[i].debt || Overflow !== tbl[i].ovf) begin
        n_fail++;
        $display("FAIL %s got req=%0b urg=%0b debt=%0d ovf=%0b want req=%0b urg=%0b debt=%0d ovf=%0b",
                 tbl[i].name, RefReq, RefUrg, Debt, Overflow,
                 tbl[i].req, tbl[i].urg, tbl[i].debt, tbl[i].ovf);
      end
    end

    // Randomized traffic: bursty acks of random length, occasional En drops and resets.
    begin
      bit ack_r = 0;
      for (int c = 0; c < 20000; c++) begin
        bit rst_r, en_r;
        rst_r = ($urandom_range(0, 4999) == 0);
        en_r  = ($urandom_range(0, 15) != 0);
        if (ack_r) ack_r = ($urandom_range(0, 1) == 1);
        else       ack_r = ($urandom_range(0, 149) == 0);
        cyc(rst_r, en_r, ack_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
